render_number: RTL
==================

RENDER_NUMBER -- requirements
Module: render_number

Interface
REQ-001 SHALL have parameter NDIGITS, default 4, meaning the number of decimal digits rendered.
REQ-002 SHALL have parameter VAL_W, default 14, meaning the width of the binary value input.
REQ-003 SHALL have parameter DIGIT_CYCLES, default 864, meaning the clk cycles allotted to the downstream digit stage per digit (4 x 12 x 18).
REQ-004 SHALL have port clk, input, 1 bit: the single 100 MHz clock.
REQ-005 SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit: single-cycle request to render a value.
REQ-007 SHALL have port value, input, VAL_W bits: unsigned binary number to render.
REQ-008 SHALL have ports top and left, input, 10 bits each: screen position of the most-significant digit.
REQ-009 SHALL have port busy, output, 1 bit: high from the accepted start until done.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at the end of the sequence.
REQ-011 SHALL have port digit_addr, output, 12 bits: ROM base address of the current glyph.
REQ-012 SHALL have ports dig_top and dig_left, output, 10 bits each: position of the current digit.
REQ-013 SHALL have port dig_rstn, output, 1 bit: active-low restart strobe for the digit stage.

Function
REQ-014 SHALL sample value, top and left on start while in IDLE; start SHALL be ignored while busy.
REQ-015 SHALL saturate value to 10^NDIGITS-1 when it exceeds that value, before conversion.
REQ-016 SHALL implement the FSM IDLE->CONV->LOAD->WAIT->(LOAD | DONE)->IDLE.
REQ-017 CONV SHALL perform shift-add-3 binary-to-BCD conversion in exactly VAL_W cycles.
REQ-018 LOAD SHALL last 1 cycle and set digit_addr = d x 216, dig_left = left + 12 x i and dig_top = top, where d is the BCD digit and i is the index (0 = MSD).
REQ-019 dig_rstn SHALL be low during LOAD only and high otherwise.
REQ-020 digit_addr, dig_top and dig_left SHALL hold stable throughout WAIT.
REQ-021 WAIT SHALL last exactly DIGIT_CYCLES cycles; it SHALL then go to LOAD for i+1, or to DONE after i = NDIGITS-1.
REQ-022 DONE SHALL last 1 cycle with done=1 and busy=0 on the following cycle.
REQ-023 Total latency SHALL be VAL_W + NDIGITS x (1 + DIGIT_CYCLES) + 1 cycles from start to done.
REQ-024 Position arithmetic SHALL be modulo 2^10 (wraps, no clamp).
REQ-025 A start coincident with done SHALL be ignored.

Reset
REQ-026 rstn low SHALL asynchronously force IDLE with busy=0, done=0, dig_rstn=0, digit_addr=0, dig_top=0 and dig_left=0, aborting any sequence in progress.
REQ-027 After rstn rises, dig_rstn SHALL go high on the first clk edge, and the block SHALL accept start from the first clk edge.

Configuration
REQ-028 Macro RENDER_NUMBER_LZB_EN defined: leading zero digits SHALL be skipped (no LOAD/WAIT, positions unchanged for the remaining digits); the least-significant digit SHALL always be rendered.
REQ-029 Macro RENDER_NUMBER_LZB_EN undefined: all NDIGITS digits SHALL be rendered, including leading zeros.

Structure
REQ-030 The shared package render_pkg SHALL hold DIGIT_W=12, DIGIT_H=18, DIGIT_PIXELS=216, the DIGIT_CYCLES default and the FSM state typedef.
REQ-031 Conversion SHALL live in the sub-module bin2bcd (start/done handshake, iterative, VAL_W cycles).

Verification
REQ-032 value=1234, top=100, left=200, start -> digit_addr 216,432,648,864 and dig_left 200,212,224,236; done at cycle 14+4x865+1.
REQ-033 value=16383 -> saturates, rendering four 9s (digit_addr=1944 each).
REQ-034 LZB_EN with value=7 -> a single LOAD with digit_addr=1512 and dig_left=236; value=0 -> a single LOAD with digit_addr=0.
REQ-035 start pulsed in mid-WAIT -> ignored; the sequence and its outputs are unchanged.
REQ-036 rstn pulsed low during the digit-2 WAIT -> IDLE immediately with outputs at reset values; a new start renders correctly.
REQ-037 left=1020 -> dig_left 1020,8,20,32 (wrap).

Source files
------------

// File: rtl/render_pkg.sv
// rtl/render_pkg.sv - Glyph geometry, timing defaults and FSM state type for render_number.
`timescale 1ns/1ps
package render_pkg;

    localparam int DIGIT_W          = 12;
    localparam int DIGIT_H          = 18;
    localparam int DIGIT_PIXELS     = DIGIT_W * DIGIT_H;
    localparam int DIGIT_CYCLES_DEF = 4 * DIGIT_PIXELS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_LOAD,
        S_WAIT,
        S_DONE
    } state_e;

    // Largest value representable in ndigits decimal digits (10^ndigits - 1).
    function automatic longint unsigned max_value(input int ndigits);
        longint unsigned p;
        p = 64'd1;
        for (int k = 0; k < ndigits; k++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/bin2bcd.sv
// rtl/bin2bcd.sv - Iterative shift-add-3 binary to BCD converter, VAL_W cycles per conversion.
`timescale 1ns/1ps
module bin2bcd #(
    parameter int VAL_W   = 14,
    parameter int NDIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [VAL_W-1:0]       value,
    output logic                   done,
    output logic [4*NDIGITS-1:0]   bcd
);

    localparam int BCD_W = 4 * NDIGITS;
    localparam int CNT_W = $clog2(VAL_W + 1);

    logic [VAL_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [BCD_W-1:0] adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int k = 0; k < NDIGITS; k++) begin
            if (r[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = r[4*k +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // The load edge already performs the first shift (no add-3 needed on an
    // all-zero BCD field), so done is registered in the final step's cycle.
    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        adj    = add3(bcd_q);
        if (start) begin
            bcd_d  = BCD_W'(value[VAL_W-1]);
            bin_d  = value << 1;
            cnt_d  = CNT_W'(VAL_W - 1);
            busy_d = (VAL_W > 1);
            done_d = (VAL_W == 1);
        end else if (busy_q) begin
            {bcd_d, bin_d} = {adj[BCD_W-2:0], bin_q, 1'b0};
            cnt_d          = cnt_q - CNT_W'(1);
            done_d         = (cnt_q == CNT_W'(1));
            busy_d         = (cnt_q != CNT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/render_number.sv
// rtl/render_number.sv - Sequences per-digit glyph loads for a decimal number; RENDER_NUMBER_LZB_EN skips leading zeros.
`timescale 1ns/1ps
module render_number
    import render_pkg::*;
#(
    parameter int NDIGITS      = 4,
    parameter int VAL_W        = 14,
    parameter int DIGIT_CYCLES = DIGIT_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [VAL_W-1:0] value,
    input  logic [9:0]       top,
    input  logic [9:0]       left,
    output logic             busy,
    output logic             done,
    output logic [11:0]      digit_addr,
    output logic [9:0]       dig_top,
    output logic [9:0]       dig_left,
    output logic             dig_rstn
);

    localparam int BCD_W = 4 * NDIGITS;
    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam longint unsigned MAX_VAL = max_value(NDIGITS);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [9:0]       org_top_q, org_top_d;
    logic [9:0]       org_left_q, org_left_d;
    logic [11:0]      addr_q, addr_d;
    logic [9:0]       dtop_q, dtop_d;
    logic [9:0]       dleft_q, dleft_d;
    logic             drstn_q, drstn_d;

    logic             accept;
    logic [VAL_W-1:0] sat_value;
    logic             conv_done;
    logic [BCD_W-1:0] bcd;
    logic             enter_load;
    logic [IDX_W-1:0] load_idx;
    logic [IDX_W-1:0] first_idx;
    logic [3:0]       digit;

    assign accept = (state_q == S_IDLE) && start;

    always_comb begin
        sat_value = value;
        if (64'(value) > MAX_VAL) begin
            sat_value = VAL_W'(MAX_VAL);
        end
    end

    bin2bcd #(
        .VAL_W   (VAL_W),
        .NDIGITS (NDIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rstn  (rstn),
        .start (accept),
        .value (sat_value),
        .done  (conv_done),
        .bcd   (bcd)
    );

    // Index 0 is the most-significant digit.
`ifdef RENDER_NUMBER_LZB_EN
    always_comb begin
        first_idx = IDX_W'(NDIGITS - 1);
        for (int k = NDIGITS - 1; k >= 0; k--) begin
            if (bcd[4*(NDIGITS-1-k) +: 4] != 4'd0) begin
                first_idx = IDX_W'(k);
            end
        end
    end
`else
    assign first_idx = '0;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wcnt_d     = wcnt_q;
        org_top_d  = org_top_q;
        org_left_d = org_left_q;
        addr_d     = addr_q;
        dtop_d     = dtop_q;
        dleft_d    = dleft_q;
        enter_load = 1'b0;
        load_idx   = idx_q;
        digit      = 4'd0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_CONV;
                    org_top_d  = top;
                    org_left_d = left;
                end
            end
            S_CONV: begin
                if (conv_done) begin
                    state_d    = S_LOAD;
                    enter_load = 1'b1;
                    load_idx   = first_idx;
                end
            end
            S_LOAD: begin
                state_d = S_WAIT;
                wcnt_d  = CNT_W'(DIGIT_CYCLES - 1);
            end
            S_WAIT: begin
                if (wcnt_q == '0) begin
                    if (idx_q == IDX_W'(NDIGITS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_LOAD;
                        enter_load = 1'b1;
                        load_idx   = idx_q + IDX_W'(1);
                    end
                end else begin
                    wcnt_d = wcnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Glyph outputs are registered on entry to LOAD and then held through WAIT.
        if (enter_load) begin
            for (int k = 0; k < NDIGITS; k++) begin
                if (load_idx == IDX_W'(k)) begin
                    digit = bcd[4*(NDIGITS-1-k) +: 4];
                end
            end
            idx_d   = load_idx;
            addr_d  = 12'(digit) * 12'(DIGIT_PIXELS);
            dtop_d  = org_top_q;
            dleft_d = org_left_q + 10'(DIGIT_W) * 10'(load_idx);
        end

        drstn_d = (state_d != S_LOAD);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            wcnt_q     <= '0;
            org_top_q  <= '0;
            org_left_q <= '0;
            addr_q     <= '0;
            dtop_q     <= '0;
            dleft_q    <= '0;
            drstn_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wcnt_q     <= wcnt_d;
            org_top_q  <= org_top_d;
            org_left_q <= org_left_d;
            addr_q     <= addr_d;
            dtop_q     <= dtop_d;
            dleft_q    <= dleft_d;
            drstn_q    <= drstn_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign digit_addr = addr_q;
    assign dig_top    = dtop_q;
    assign dig_left   = dleft_q;
    assign dig_rstn   = drstn_q;

endmodule
